// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 scan sequencer.
// Walks rows and bit planes. For each plane it fetches one row of every
// segment through a 1-cycle-latency read port and shifts it out on the
// panel clock. It then latches the row and holds OE low for a
// binary-weighted time.
// Optional feature: define HUB75_DEADTIME_EN to insert a 4-cycle DEAD state
// before the plane-0 latch. The row address moves in DEAD instead of LATCH.
module hub75_scan_ctrl #(
  parameter  int hpixel_p     = 64,
  parameter  int vpixel_p     = 64,
  parameter  int bpp_p        = 8,
  parameter  int segments_p   = 2,
  parameter  int oe_base_p    = 4,
  localparam int rows_p       = vpixel_p / segments_p,
  localparam int addr_width_p = $clog2(hpixel_p * vpixel_p),
  localparam int row_width_p  = $clog2(rows_p)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_enable,
  output logic [addr_width_p-1:0]                o_rd_addr,
  input  logic [segments_p-1:0][2:0][bpp_p-1:0]  i_rd_data,
  output logic [segments_p-1:0][2:0]             o_hub_rgb,
  output logic                                   o_hub_clk,
  output logic                                   o_hub_lat,
  output logic                                   o_hub_oe_n,
  output logic [row_width_p-1:0]                 o_hub_addr,
  output logic                                   o_frame_done,
  output logic                                   o_busy
);

  // Shift phase: two system clocks per column plus two tail cycles.
  // In the tail the last column is clocked into the panel.
  localparam int shift_len_p = 2 * hpixel_p + 2;
  localparam int shift_w_p   = $clog2(shift_len_p);
  localparam int disp_w_p    = $clog2(oe_base_p << (bpp_p - 1)) + 1;
  localparam int plane_w_p   = (bpp_p > 1) ? $clog2(bpp_p) : 1;

  localparam logic [shift_w_p-1:0]   shift_last_c = shift_w_p'(shift_len_p - 1);
  localparam logic [shift_w_p-1:0]   shift_cols_c = shift_w_p'(2 * hpixel_p);
  localparam logic [shift_w_p-1:0]   dead_last_c  = shift_w_p'(3);
  localparam logic [plane_w_p-1:0]   plane_last_c = plane_w_p'(bpp_p - 1);
  localparam logic [row_width_p-1:0] row_last_c   = row_width_p'(rows_p - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    DEAD    = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_e;

  // Sequencer state.
  state_e                 state_q, state_d;
  logic [shift_w_p-1:0]   shift_cnt_q, shift_cnt_d;
  logic [disp_w_p-1:0]    disp_cnt_q, disp_cnt_d;
  logic [row_width_p-1:0] row_q, row_d;
  logic [plane_w_p-1:0]   plane_q, plane_d;

  // Registered panel-side outputs.
  logic [addr_width_p-1:0]    rd_addr_q, rd_addr_d;
  logic [segments_p-1:0][2:0] hub_rgb_q, hub_rgb_d;
  logic                       hub_clk_q, hub_clk_d;
  logic                       hub_lat_q, hub_lat_d;
  logic                       hub_oe_n_q, hub_oe_n_d;
  logic [row_width_p-1:0]     hub_addr_q, hub_addr_d;
  logic                       frame_done_q, frame_done_d;
  logic                       busy_q, busy_d;

  // Current bit plane picked out of the incoming pixel word.
  logic [segments_p-1:0][2:0] rgb_sel;
  logic [shift_w_p-2:0]       col_d;

  // Last display-counter value for a given plane (OE-low time minus one).
  function automatic logic [disp_w_p-1:0] disp_last_f(input logic [plane_w_p-1:0] plane);
    return (disp_w_p'(oe_base_p) << plane) - disp_w_p'(1);
  endfunction

  for (genvar gi = 0; gi < segments_p; gi++) begin : g_seg
    for (genvar gc = 0; gc < 3; gc++) begin : g_ch
      assign rgb_sel[gi][gc] = i_rd_data[gi][gc][plane_q];
    end
  end

  // Next-state logic: state, phase counters, row and plane bookkeeping.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    disp_cnt_d  = disp_cnt_q;
    row_d       = row_q;
    plane_d     = plane_q;
    unique case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d     = SHIFT;
          shift_cnt_d = '0;
          row_d       = '0;
          plane_d     = '0;
        end
      end
      SHIFT: begin
        if (shift_cnt_q == shift_last_c) begin
          shift_cnt_d = '0;
`ifdef HUB75_DEADTIME_EN
          // Only plane 0 starts a new row, so only it needs settle time.
          state_d = (plane_q == '0) ? DEAD : LATCH;
`else
          state_d = LATCH;
`endif
        end else begin
          shift_cnt_d = shift_cnt_q + shift_w_p'(1);
        end
      end
      DEAD: begin
        // The shift counter is idle here, so it times the dead period.
        if (shift_cnt_q == dead_last_c) begin
          shift_cnt_d = '0;
          state_d     = LATCH;
        end else begin
          shift_cnt_d = shift_cnt_q + shift_w_p'(1);
        end
      end
      LATCH: begin
        state_d    = DISPLAY;
        disp_cnt_d = '0;
      end
      DISPLAY: begin
        if (disp_cnt_q == disp_last_f(plane_q)) begin
          disp_cnt_d = '0;
          state_d    = SHIFT;
          if (plane_q == plane_last_c) begin
            plane_d = '0;
            if (row_q == row_last_c) begin
              row_d = '0;
              // Frame boundary: the only point besides IDLE where enable matters.
              if (!i_enable) begin
                state_d = IDLE;
              end
            end else begin
              row_d = row_q + row_width_p'(1);
            end
          end else begin
            plane_d = plane_q + plane_w_p'(1);
          end
        end else begin
          disp_cnt_d = disp_cnt_q + disp_w_p'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    col_d        = shift_cnt_d[shift_w_p-1:1];
    rd_addr_d    = rd_addr_q;
    hub_rgb_d    = hub_rgb_q;
    hub_addr_d   = hub_addr_q;
    hub_clk_d    = (state_d == SHIFT) && shift_cnt_d[0] && (shift_cnt_d >= shift_w_p'(3));
    hub_lat_d    = (state_d == LATCH);
    hub_oe_n_d   = (state_d != DISPLAY);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DISPLAY) && (disp_cnt_d == disp_last_f(plane_d)) &&
                   (plane_d == plane_last_c) && (row_d == row_last_c);

    // Issue the read for column c on even shift cycles 2c.
    if ((state_d == SHIFT) && !shift_cnt_d[0] && (shift_cnt_d < shift_cols_c)) begin
      rd_addr_d = addr_width_p'(row_d) * addr_width_p'(hpixel_p) + addr_width_p'(col_d);
    end

    // Read data is valid on the odd cycle after the address; capture it then.
    if ((state_q == SHIFT) && shift_cnt_q[0] && (shift_cnt_q < shift_cols_c)) begin
      hub_rgb_d = rgb_sel;
    end

`ifdef HUB75_DEADTIME_EN
    // Row select moves on DEAD entry, giving the panel time to settle before LATCH.
    if ((state_d == DEAD) && (state_q != DEAD)) begin
      hub_addr_d = row_d;
    end
`else
    // Row select moves with the latch pulse while OE is still high.
    if (state_d == LATCH) begin
      hub_addr_d = row_d;
    end
`endif
  end

  // All state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_cnt_q  <= '0;
      disp_cnt_q   <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      rd_addr_q    <= '0;
      hub_rgb_q    <= '0;
      hub_clk_q    <= 1'b0;
      hub_lat_q    <= 1'b0;
      hub_oe_n_q   <= 1'b1;
      hub_addr_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_cnt_q  <= shift_cnt_d;
      disp_cnt_q   <= disp_cnt_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      rd_addr_q    <= rd_addr_d;
      hub_rgb_q    <= hub_rgb_d;
      hub_clk_q    <= hub_clk_d;
      hub_lat_q    <= hub_lat_d;
      hub_oe_n_q   <= hub_oe_n_d;
      hub_addr_q   <= hub_addr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign o_rd_addr    = rd_addr_q;
  assign o_hub_rgb    = hub_rgb_q;
  assign o_hub_clk    = hub_clk_q;
  assign o_hub_lat    = hub_lat_q;
  assign o_hub_oe_n   = hub_oe_n_q;
  assign o_hub_addr   = hub_addr_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed testbench for hub75_scan_ctrl with a small 8x4, 2-plane, 2-segment panel.
// The read source returns 0b10 on every channel at address 0 and zero elsewhere.
module tb_hub75_scan_ctrl;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int BPP = 2;
  localparam int SEG = 2;
  localparam int OEB = 4;
  localparam int AW  = $clog2(H * V);
  localparam int RW  = $clog2(V / SEG);
`ifdef HUB75_DEADTIME_EN
  localparam int FRAME_P   = 108;
  localparam int ADDR_LEAD = 4;
  localparam int FIRST_LAT = 22;
`else
  localparam int FRAME_P   = 100;
  localparam int ADDR_LEAD = 0;
  localparam int FIRST_LAT = 18;
`endif
  localparam logic [AW+SEG*3+5:0] RST_VEC = (AW+SEG*3+6)'(8);

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          en;
  logic [AW-1:0]                 rd_addr;
  logic [SEG-1:0][2:0][BPP-1:0]  rd_data = '0;
  logic [SEG-1:0][2:0]           hub_rgb;
  logic                          hub_clk, hub_lat, hub_oe_n, frame_done, busy;
  logic [RW-1:0]                 hub_addr;
  logic [AW+SEG*3+5:0]           out_vec;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hub75_scan_ctrl #(
    .hpixel_p(H), .vpixel_p(V), .bpp_p(BPP), .segments_p(SEG), .oe_base_p(OEB)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(en),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_hub_rgb(hub_rgb), .o_hub_clk(hub_clk), .o_hub_lat(hub_lat),
    .o_hub_oe_n(hub_oe_n), .o_hub_addr(hub_addr),
    .o_frame_done(frame_done), .o_busy(busy)
  );

  assign out_vec = {rd_addr, hub_rgb, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_done, busy};

  // Registered read source with one cycle of latency.
  always @(posedge clk) begin
    if (rd_addr == '0) rd_data <= {(SEG*3){2'b10}};
    else               rd_data <= '0;
  end

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_vec !== RST_VEC) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", out_vec, RST_VEC);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_vec !== RST_VEC) begin
        tests_failed++;
        $display("FAIL idle_disabled cyc %0d: got %h expected %h", i, out_vec, RST_VEC);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_frame();
    int cyc = 0, done_cnt = 0, last_done = 0, lat_cnt = 0, edges = 0;
    int oe_run = 0, last_lat_plane = 0, addr_chg_cyc = 0, plane, row, exp_addr, exp_oe;
    bit addr_chg = 0, first_clk_seen = 0;
    logic p_clk, p_lat, p_oe;
    logic [RW-1:0] p_addr;
    logic [SEG-1:0][2:0] exp_rgb;
    en = 1'b1;
    p_clk = hub_clk; p_lat = hub_lat; p_oe = hub_oe_n; p_addr = hub_addr;
    while (done_cnt < 3 && cyc < 4 * FRAME_P) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_run cyc %0d: got %b expected 1", cyc, busy);
      end
      if (!first_clk_seen && hub_clk === 1'b1) begin
        first_clk_seen = 1;
        tests_run++;
        if (cyc != 3) begin
          tests_failed++;
          $display("FAIL first_hub_clk: got cycle %0d expected 3", cyc);
        end
      end
      if (hub_clk === 1'b1 && p_clk === 1'b0) begin
        plane    = lat_cnt % 2;
        row      = (lat_cnt / 2) % 2;
        exp_rgb  = (row == 0 && plane == 1 && edges == 0) ? '1 : '0;
        exp_addr = row * H + ((edges < H - 1) ? edges + 1 : H - 1);
        tests_run += 2;
        if (hub_rgb !== exp_rgb) begin
          tests_failed++;
          $display("FAIL rgb row %0d plane %0d col %0d: got %b expected %b", row, plane, edges, hub_rgb, exp_rgb);
        end
        if (rd_addr !== AW'(exp_addr)) begin
          tests_failed++;
          $display("FAIL rd_addr row %0d col %0d: got %0d expected %0d", row, edges, rd_addr, exp_addr);
        end
        edges++;
      end
      if (hub_addr !== p_addr) begin
        addr_chg     = 1;
        addr_chg_cyc = cyc;
      end
      if (hub_oe_n === 1'b0 && p_oe === 1'b0) begin
        tests_run++;
        if (hub_addr !== p_addr) begin
          tests_failed++;
          $display("FAIL addr_stable_oe cyc %0d: got %0d expected %0d", cyc, hub_addr, p_addr);
        end
      end
      if (hub_lat === 1'b1) begin
        tests_run += 3;
        if ({p_lat, hub_oe_n} !== 2'b01) begin
          tests_failed++;
          $display("FAIL lat_shape cyc %0d: got prev_lat,oe_n=%b expected 01", cyc, {p_lat, hub_oe_n});
        end
        if (edges != H) begin
          tests_failed++;
          $display("FAIL clk_edges latch %0d: got %0d expected %0d", lat_cnt, edges, H);
        end
        if (hub_addr !== RW'((lat_cnt / 2) % 2)) begin
          tests_failed++;
          $display("FAIL hub_addr latch %0d: got %0d expected %0d", lat_cnt, hub_addr, (lat_cnt / 2) % 2);
        end
        if (lat_cnt % 2 == 0 && addr_chg) begin
          tests_run++;
          if (cyc - addr_chg_cyc != ADDR_LEAD) begin
            tests_failed++;
            $display("FAIL addr_lead latch %0d: got %0d expected %0d", lat_cnt, cyc - addr_chg_cyc, ADDR_LEAD);
          end
        end
        if (lat_cnt == 0) begin
          tests_run++;
          if (cyc != FIRST_LAT) begin
            tests_failed++;
            $display("FAIL first_lat: got cycle %0d expected %0d", cyc, FIRST_LAT);
          end
        end
        addr_chg       = 0;
        edges          = 0;
        last_lat_plane = lat_cnt % 2;
        lat_cnt++;
      end
      if (hub_oe_n === 1'b0) begin
        oe_run++;
      end else if (p_oe === 1'b0) begin
        exp_oe = (last_lat_plane == 1) ? 8 : 4;
        tests_run++;
        if (oe_run != exp_oe) begin
          tests_failed++;
          $display("FAIL oe_len plane %0d: got %0d expected %0d", last_lat_plane, oe_run, exp_oe);
        end
        oe_run = 0;
      end
      if (frame_done === 1'b1) begin
        tests_run += 2;
        if (done_cnt == 0 && cyc != FRAME_P - 1) begin
          tests_failed++;
          $display("FAIL first_frame_done: got cycle %0d expected %0d", cyc, FRAME_P - 1);
        end
        if (done_cnt > 0 && cyc - last_done != FRAME_P) begin
          tests_failed++;
          $display("FAIL frame_period: got %0d expected %0d", cyc - last_done, FRAME_P);
        end
        if (lat_cnt != 4 * (done_cnt + 1)) begin
          tests_failed++;
          $display("FAIL latches_per_frame: got %0d expected %0d", lat_cnt, 4 * (done_cnt + 1));
        end
        last_done = cyc;
        done_cnt++;
        $display("[TB] frame %0d done at cycle %0d", done_cnt, cyc);
      end
      p_clk = hub_clk; p_lat = hub_lat; p_oe = hub_oe_n; p_addr = hub_addr;
      cyc++;
    end
    tests_run++;
    if (done_cnt < 3) begin
      tests_failed++;
      $display("FAIL frame_timeout: got %0d frames expected 3", done_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int k = 0;
    repeat (10) @(negedge clk);
    en = 1'b0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 2 * FRAME_P);
    tests_run++;
    if (k != FRAME_P - 10) begin
      tests_failed++;
      $display("FAIL drop_frame_done: got %0d cycles expected %0d", k, FRAME_P - 10);
    end
    @(negedge clk);
    tests_run++;
    if ({busy, hub_oe_n, hub_lat, hub_clk} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL drop_idle: got busy,oe_n,lat,clk=%b expected 0100", {busy, hub_oe_n, hub_lat, hub_clk});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if ({busy, frame_done, hub_lat} !== 3'b000) begin
        tests_failed++;
        $display("FAIL drop_stay_idle cyc %0d: got %b expected 000", i, {busy, frame_done, hub_lat});
      end
    end
    $display("[TB] test_enable_drop done after %0d cycles", k);
  endtask

  task automatic test_reset_mid_display();
    int k = 0;
    en = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (hub_oe_n !== 1'b0 && k < 80);
    tests_run++;
    if (hub_oe_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL display_timeout: got oe_n=%b expected 0", hub_oe_n);
    end
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_vec !== RST_VEC) begin
      tests_failed++;
      $display("FAIL mid_display_reset: got %h expected %h", out_vec, RST_VEC);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if ({hub_lat, busy, hub_oe_n} !== 3'b001) begin
        tests_failed++;
        $display("FAIL post_reset_quiet cyc %0d: got lat,busy,oe_n=%b expected 001", i, {hub_lat, busy, hub_oe_n});
      end
    end
    $display("[TB] test_reset_mid_display done");
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_frame();
    test_enable_drop();
    test_reset_mid_display();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
